fb_rect_writer: RTL and testbench
=================================

// Module: fb_rect_writer
// PURPOSE
//  Write-side engine for the double-buffered 320x180 RGB565 frame buffer: drives its write port
//  (write_data, write_addr, write_enable, swap_buffer). Accepts draw commands over valid/ready:
//  FILL (solid rectangle), CLEAR (whole screen) and SWAP (present the back buffer).
//  Emits one pixel write per clock. Sits between the game/CPU command path and frame_buffer.
// PARAMETERS
//  FB_WIDTH   320  write-side buffer width in pixels
//  FB_HEIGHT  180  write-side buffer height in pixels
//  (derived) AW=$clog2(FB_WIDTH*FB_HEIGHT), XW=$clog2(FB_WIDTH+1), YW=$clog2(FB_HEIGHT+1)
// PORTS
//  clk_in        in   1   single clock; the integrator also ties the buffer's write clock to it
//  rst_in        in   1   synchronous reset, active-high
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   engine idle; a command is accepted when cmd_valid && cmd_ready
//  cmd_op        in   2   fb_op_t: FILL=0, CLEAR=1, SWAP=2; 3 is reserved (NOP)
//  cmd_x         in   XW  rectangle left column (FILL only)
//  cmd_y         in   YW  rectangle top row (FILL only)
//  cmd_w         in   XW  rectangle width in pixels (FILL only)
//  cmd_h         in   YW  rectangle height in pixels (FILL only)
//  cmd_color     in   16  RGB565 colour (FILL/CLEAR)
//  write_data    out  16  pixel colour to frame buffer
//  write_addr    out  AW  linear address, x + FB_WIDTH*y (unmirrored)
//  write_enable  out  1   single-cycle write strobe per pixel
//  swap_buffer   out  1   single-cycle swap pulse
//  busy          out  1   equals !cmd_ready
// BEHAVIOUR
//  - Reset: state IDLE; write_enable=0, swap_buffer=0, write_addr=0, write_data=0.
//    cmd_ready=0 while rst_in is high. Reset during DRAW aborts the command: no further writes, no swap.
//  - cmd_ready = (state==IDLE) && !rst_in. It is combinational from state; cmd fields are sampled
//    only on acceptance.
//  - FSM: IDLE -> DRAW on FILL/CLEAR with a non-empty clipped rectangle; IDLE -> SWAP on SWAP;
//    IDLE -> IDLE on NOP or an empty rectangle. SWAP -> IDLE after 1 cycle.
//    DRAW -> IDLE in the cycle the last pixel is issued.
//  - Clipping (XW+1 / YW+1 bit arithmetic, no overflow): x_end = min(x+w, FB_WIDTH),
//    y_end = min(y+h, FB_HEIGHT).
//    The rectangle is empty if w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT.
//    CLEAR is identical to FILL with x=0, y=0, w=FB_WIDTH, h=FB_HEIGHT.
//  - Latency: command accepted at edge N -> first write_enable is high in cycle N+1.
//    Pixels are issued in raster order (row-major, left to right), one per cycle, with no gaps.
//    A clipped rectangle of P pixels occupies cycles N+1..N+P. cmd_ready is high again in cycle N+P+1.
//    An empty rectangle or a NOP gives cmd_ready high in cycle N+1 with no writes.
//  - Address generation has no multiplier. row_base starts at FB_WIDTH*y, computed as a
//    shift-add constant product. row_base += FB_WIDTH on each row advance.
//    write_addr = row_base + col, registered.
//  - SWAP: swap_buffer is high for exactly cycle N+1. Because commands are serialized, the swap
//    always follows the last write of every earlier command.
//    Back-to-back SWAPs produce pulses at least 2 cycles apart.
//  - cmd_valid while busy: ignored. The requester holds the command until it is accepted.
//  - write_data holds cmd_color throughout DRAW. Outside DRAW, write_enable=0 and
//    write_data/write_addr hold their last values.
// STRUCTURE
//  - fb_pkg: typedef enum logic[1:0] fb_op_t {FILL, CLEAR, SWAP, NOP}; FB_WIDTH/FB_HEIGHT
//    defaults; rgb565_t typedef.
//  - Sub-module fb_rect_clip: combinational clip of (x,y,w,h) to x_start, x_end, y_start, y_end
//    and an empty flag. Instantiated once.
//  - Top: FSM, col/row counters, row_base accumulator, output registers.
// TESTING
//  1. FILL x=10,y=5,w=3,h=2,color=16'hF800 -> write_addr 1610,1611,1612,1930,1931,1932 in 6
//     consecutive cycles starting the cycle after acceptance; write_data=F800; cmd_ready low for
//     exactly 6 cycles.
//  2. Clip: FILL x=318,y=179,w=5,h=4 -> exactly 2 writes, addr 57598,57599, then ready.
//  3. Empty: FILL x=320 (and separately w=0) -> zero write_enable; cmd_ready high 1 cycle after
//     acceptance.
//  4. CLEAR color=16'h0000 -> 57600 writes, addr 0..57599 contiguous, no gaps, then ready.
//  5. FILL, then SWAP, then SWAP -> each swap_buffer pulse is 1 cycle wide; the first pulse is
//     after the final write_enable; the pulses are at least 2 cycles apart.
//  6. rst_in asserted at the 3rd pixel of a 10x10 FILL -> write_enable low from the next edge;
//     no further writes and no swap; cmd_ready high the cycle after rst_in drops.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and size defaults for the frame-buffer write engine.
// Include this package in any file that uses fb_op_t or rgb565_t.
package fb_pkg;

   localparam int FB_WIDTH_DEFAULT  = 320;
   localparam int FB_HEIGHT_DEFAULT = 180;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      CLEAR = 2'd1,
      SWAP  = 2'd2,
      NOP   = 2'd3
   } fb_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_SWAP = 2'd2
   } fb_state_t;

   typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a requested rectangle against the frame-buffer bounds.
// Sums are one bit wider than the operands, so x+w and y+h cannot overflow.
module fb_rect_clip import fb_pkg::*; #(
   parameter int FB_WIDTH  = FB_WIDTH_DEFAULT,
   parameter int FB_HEIGHT = FB_HEIGHT_DEFAULT,
   parameter int XW        = $clog2(FB_WIDTH + 1),
   parameter int YW        = $clog2(FB_HEIGHT + 1)
) (
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [XW-1:0] w,
   input  logic [YW-1:0] h,
   output logic [XW-1:0] x_start,
   output logic [XW-1:0] x_end,
   output logic [YW-1:0] y_start,
   output logic [YW-1:0] y_end,
   output logic          empty
);

   localparam logic [XW:0] W_EXT = (XW+1)'(FB_WIDTH);
   localparam logic [YW:0] H_EXT = (YW+1)'(FB_HEIGHT);

   logic [XW:0] x_sum;
   logic [YW:0] y_sum;

   always_comb begin
      x_sum   = {1'b0, x} + {1'b0, w};
      y_sum   = {1'b0, y} + {1'b0, h};
      x_start = x;
      y_start = y;
      x_end   = (x_sum > W_EXT) ? W_EXT[XW-1:0] : x_sum[XW-1:0];
      y_end   = (y_sum > H_EXT) ? H_EXT[YW-1:0] : y_sum[YW-1:0];
      empty   = (w == '0) || (h == '0) || ({1'b0, x} >= W_EXT) || ({1'b0, y} >= H_EXT);
   end

endmodule

// File: rtl/fb_rect_writer.sv
// Write-side engine for the double-buffered frame buffer: turns FILL/CLEAR/SWAP
// commands into one pixel write per clock in raster order, or a single swap pulse.
module fb_rect_writer import fb_pkg::*; #(
   parameter int   FB_WIDTH  = FB_WIDTH_DEFAULT,
   parameter int   FB_HEIGHT = FB_HEIGHT_DEFAULT,
   localparam int  AW        = $clog2(FB_WIDTH * FB_HEIGHT),
   localparam int  XW        = $clog2(FB_WIDTH + 1),
   localparam int  YW        = $clog2(FB_HEIGHT + 1)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  fb_op_t        cmd_op,
   input  logic [XW-1:0] cmd_x,
   input  logic [YW-1:0] cmd_y,
   input  logic [XW-1:0] cmd_w,
   input  logic [YW-1:0] cmd_h,
   input  rgb565_t       cmd_color,
   output rgb565_t       write_data,
   output logic [AW-1:0] write_addr,
   output logic          write_enable,
   output logic          swap_buffer,
   output logic          busy
);

   // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready.
   // cmd_ready depends only on state and reset, never on cmd_valid; the requester
   // holds all cmd_* fields stable until that edge, and they are sampled only there.

   fb_state_t     state, state_next;
   logic          accept;
   logic [XW-1:0] clip_x, clip_w, x_start, x_end;
   logic [YW-1:0] clip_y, clip_h, y_start, y_end;
   logic          clip_empty;
   logic [XW-1:0] col, x_first, x_last;
   logic [YW-1:0] row, y_last;
   logic [AW-1:0] row_base, start_base;
   logic          last_col, last_px;

   // Constant product r*FB_WIDTH as a sum of shifted copies of r.
   function automatic logic [AW-1:0] times_width(input logic [YW-1:0] r);
      logic [AW-1:0] acc;
      acc = '0;
      for (int i = 0; i < AW; i++) begin
         if (FB_WIDTH[i]) acc = acc + (AW'(r) << i);
      end
      return acc;
   endfunction

   assign cmd_ready = (state == ST_IDLE) && !rst_in;
   assign busy      = !cmd_ready;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      clip_x = cmd_x;
      clip_y = cmd_y;
      clip_w = cmd_w;
      clip_h = cmd_h;
      if (cmd_op == CLEAR) begin
         clip_x = '0;
         clip_y = '0;
         clip_w = XW'(FB_WIDTH);
         clip_h = YW'(FB_HEIGHT);
      end
   end

   fb_rect_clip #(
      .FB_WIDTH  (FB_WIDTH),
      .FB_HEIGHT (FB_HEIGHT),
      .XW        (XW),
      .YW        (YW)
   ) u_clip (
      .x       (clip_x),
      .y       (clip_y),
      .w       (clip_w),
      .h       (clip_h),
      .x_start (x_start),
      .x_end   (x_end),
      .y_start (y_start),
      .y_end   (y_end),
      .empty   (clip_empty)
   );

   assign start_base = times_width(y_start);
   assign last_col   = (col == x_last);
   assign last_px    = last_col && (row == y_last);

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_op == SWAP)
                  state_next = ST_SWAP;
               else if ((cmd_op == FILL || cmd_op == CLEAR) && !clip_empty)
                  state_next = ST_DRAW;
            end
         end
         ST_DRAW: if (last_px) state_next = ST_IDLE;
         ST_SWAP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // The first pixel is launched on the accepting edge; (col,row) always names
   // the pixel currently presented on write_addr.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         write_enable <= 1'b0;
         swap_buffer  <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
         col          <= '0;
         row          <= '0;
         row_base     <= '0;
         x_first      <= '0;
         x_last       <= '0;
         y_last       <= '0;
      end else begin
         write_enable <= 1'b0;
         swap_buffer  <= 1'b0;
         if (state == ST_IDLE && state_next == ST_DRAW) begin
            x_first      <= x_start;
            x_last       <= x_end - XW'(1);
            y_last       <= y_end - YW'(1);
            col          <= x_start;
            row          <= y_start;
            row_base     <= start_base;
            write_addr   <= start_base + AW'(x_start);
            write_data   <= cmd_color;
            write_enable <= 1'b1;
         end else if (state == ST_IDLE && state_next == ST_SWAP) begin
            swap_buffer <= 1'b1;
         end else if (state == ST_DRAW && !last_px) begin
            write_enable <= 1'b1;
            if (last_col) begin
               col        <= x_first;
               row        <= row + YW'(1);
               row_base   <= row_base + AW'(FB_WIDTH);
               write_addr <= row_base + AW'(FB_WIDTH) + AW'(x_first);
            end else begin
               col        <= col + XW'(1);
               write_addr <= row_base + AW'(col) + AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: directed table, swap and reset sequences, random commands
// checked against a pixel-enumerating reference model.
module tb_fb_rect_writer;
   import fb_pkg::*;

   localparam int W  = 320;
   localparam int H  = 180;
   localparam int AW = $clog2(W * H);
   localparam int XW = $clog2(W + 1);
   localparam int YW = $clog2(H + 1);

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          cmd_valid;
   logic          cmd_ready;
   fb_op_t        cmd_op;
   logic [XW-1:0] cmd_x, cmd_w;
   logic [YW-1:0] cmd_y, cmd_h;
   rgb565_t       cmd_color;
   rgb565_t       write_data;
   logic [AW-1:0] write_addr;
   logic          write_enable;
   logic          swap_buffer;
   logic          busy;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   fb_rect_writer dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_x        (cmd_x),
      .cmd_y        (cmd_y),
      .cmd_w        (cmd_w),
      .cmd_h        (cmd_h),
      .cmd_color    (cmd_color),
      .write_data   (write_data),
      .write_addr   (write_addr),
      .write_enable (write_enable),
      .swap_buffer  (swap_buffer),
      .busy         (busy)
   );

   // clock / cycle counter
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      fb_op_t      op;
      int          x, y, w, h;
      logic [15:0] color;
      int          exp_n, exp_first, exp_last;
   } vec_t;

   vec_t tbl[10];

   task automatic check_int(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Issues one command, watches it to completion and checks it against the model.
   task automatic run_cmd(input fb_op_t op, input int x, input int y, input int w, input int h,
                          input logic [15:0] color,
                          output int n_wr, output int first_a, output int last_a,
                          output int last_wr_cyc, output int swap_cyc);
      logic [AW-1:0] exp_q[$];
      int ex, ey, ew, eh, p, k, acc_cyc, ready_cyc, n_swap;
      int bad_addr, bad_data, bad_gap;
      ex = x; ey = y; ew = w; eh = h;
      if (op == CLEAR) begin ex = 0; ey = 0; ew = W; eh = H; end
      if (op == FILL || op == CLEAR) begin
         for (int yy = ey; yy < ey + eh && yy < H; yy++)
            for (int xx = ex; xx < ex + ew && xx < W; xx++)
               exp_q.push_back(AW'(xx + W * yy));
      end
      p = exp_q.size();
      n_wr = 0; first_a = -1; last_a = -1; last_wr_cyc = -1; swap_cyc = -1;
      n_swap = 0; bad_addr = 0; bad_data = 0; bad_gap = 0; ready_cyc = -1;

      @(negedge clk_in);
      cmd_op = op; cmd_x = XW'(x); cmd_y = YW'(y); cmd_w = XW'(w); cmd_h = YW'(h);
      cmd_color = color; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 20) begin
         @(negedge clk_in);
         k++;
      end
      if (!cmd_ready) begin
         check_int("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      acc_cyc = cyc;

      for (int c = 1; c <= p + 4; c++) begin
         @(negedge clk_in);
         if (c == 1) cmd_valid = 1'b0;
         if (write_enable) begin
            if (n_wr >= p || write_addr != exp_q[n_wr]) bad_addr++;
            if (write_data != color) bad_data++;
            if (cyc != acc_cyc + 1 + n_wr) bad_gap++;
            if (n_wr == 0) first_a = int'(write_addr);
            last_a = int'(write_addr);
            last_wr_cyc = cyc;
            n_wr++;
         end
         if (swap_buffer) begin
            n_swap++;
            swap_cyc = cyc;
         end
         if (cmd_ready) begin
            ready_cyc = cyc;
            break;
         end
      end

      check_int("n_writes", n_wr, p);
      check_int("addr_bad", bad_addr, 0);
      check_int("data_bad", bad_data, 0);
      check_int("write_gap", bad_gap, 0);
      check_int("ready_delay", ready_cyc - acc_cyc, (op == SWAP) ? 2 : p + 1);
      check_int("swap_count", n_swap, (op == SWAP) ? 1 : 0);
      if (op == SWAP) check_int("swap_delay", swap_cyc - acc_cyc, 1);
   endtask

   initial begin
      int n_wr, first_a, last_a, lw_cyc, sw_cyc, s1, s2, k, n_stray, n_notready;
      int fill_last;

      tbl[0] = '{FILL,  10,   5,   3,   2, 16'hF800,     6,  1610,  1932};
      tbl[1] = '{FILL,  318, 179,  5,   4, 16'h07E0,     2, 57598, 57599};
      tbl[2] = '{FILL,  320,  0,   5,   5, 16'h001F,     0,     0,     0};
      tbl[3] = '{FILL,  0,    0,   0,   5, 16'h1111,     0,     0,     0};
      tbl[4] = '{FILL,  0,  180,   4,   4, 16'h2222,     0,     0,     0};
      tbl[5] = '{FILL,  0,    0,   1,   1, 16'h1234,     1,     0,     0};
      tbl[6] = '{FILL,  319,  0,   1, 180, 16'hBEEF,   180,   319, 57599};
      tbl[7] = '{NOP,   0,    0,   5,   5, 16'h3333,     0,     0,     0};
      tbl[8] = '{FILL,  300, 170, 511, 255, 16'hCAFE,  200, 54700, 57599};
      tbl[9] = '{CLEAR, 5,    5,   1,   1, 16'h0000, 57600,     0, 57599};

      rst_in = 1'b1; cmd_valid = 1'b0; cmd_op = FILL;
      cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

      // reset state
      repeat (3) @(negedge clk_in);
      check_int("rst_ready", int'(cmd_ready), 0);
      check_int("rst_busy", int'(busy), 1);
      check_int("rst_we", int'(write_enable), 0);
      check_int("rst_swap", int'(swap_buffer), 0);
      check_int("rst_addr", int'(write_addr), 0);
      check_int("rst_data", int'(write_data), 0);
      rst_in = 1'b0;
      @(negedge clk_in);
      check_int("ready_after_rst", int'(cmd_ready), 1);
      check_int("busy_after_rst", int'(busy), 0);

      // directed table
      for (int i = 0; i < 10; i++) begin
         run_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].color,
                 n_wr, first_a, last_a, lw_cyc, sw_cyc);
         check_int($sformatf("tbl%0d_count", i), n_wr, tbl[i].exp_n);
         if (tbl[i].exp_n > 0) begin
            check_int($sformatf("tbl%0d_first", i), first_a, tbl[i].exp_first);
            check_int($sformatf("tbl%0d_last", i), last_a, tbl[i].exp_last);
         end
      end

      // FILL then two SWAPs
      run_cmd(FILL, 100, 100, 4, 3, 16'h5A5A, n_wr, first_a, last_a, fill_last, sw_cyc);
      run_cmd(SWAP, 0, 0, 0, 0, 16'h0, n_wr, first_a, last_a, lw_cyc, s1);
      run_cmd(SWAP, 0, 0, 0, 0, 16'h0, n_wr, first_a, last_a, lw_cyc, s2);
      check_int("swap_after_write", int'(s1 > fill_last), 1);
      check_int("swap_spacing", int'(s2 - s1 >= 2), 1);

      // reset in the middle of a 10x10 FILL
      @(negedge clk_in);
      cmd_op = FILL; cmd_x = XW'(20); cmd_y = YW'(20); cmd_w = XW'(10); cmd_h = YW'(10);
      cmd_color = 16'hABCD; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 20) begin
         @(negedge clk_in);
         k++;
      end
      check_int("rstdraw_accept", int'(cmd_ready), 1);
      @(negedge clk_in);
      cmd_valid = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      check_int("rstdraw_px3_we", int'(write_enable), 1);
      check_int("rstdraw_px3_addr", int'(write_addr), 20 * W + 22);
      rst_in = 1'b1;
      #1;
      check_int("rstdraw_ready_low", int'(cmd_ready), 0);
      n_stray = 0; n_notready = 0;
      repeat (3) begin
         @(negedge clk_in);
         if (write_enable || swap_buffer) n_stray++;
      end
      check_int("rstdraw_addr", int'(write_addr), 0);
      rst_in = 1'b0;
      repeat (4) begin
         @(negedge clk_in);
         if (write_enable || swap_buffer) n_stray++;
         if (!cmd_ready) n_notready++;
      end
      check_int("rstdraw_stray", n_stray, 0);
      check_int("rstdraw_notready", n_notready, 0);

      // random commands
      for (int i = 0; i < 40; i++) begin
         int sel, rx, ry, rw, rh;
         fb_op_t rop;
         sel = $urandom_range(0, 9);
         rx = $urandom_range(0, 330);
         ry = $urandom_range(0, 190);
         rw = $urandom_range(0, 30);
         rh = $urandom_range(0, 12);
         rop = FILL;
         if (sel == 7) rop = SWAP;
         if (sel == 8) rop = NOP;
         if (sel == 9) begin
            ry = $urandom_range(170, 190);
            rw = $urandom_range(0, 511);
            rh = $urandom_range(0, 255);
         end
         run_cmd(rop, rx, ry, rw, rh, 16'($urandom), n_wr, first_a, last_a, lw_cyc, sw_cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
